// File: rtl/extractor_pkg.sv
// Shared types and elaboration helpers for the serialising/packing blocks.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package extractor_pkg;

  // Two-state serialiser control: waiting for a word, or emitting beats
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a beat index; a single-beat word still gets a 1-bit index
  function automatic int idx_width(input int nbeats);
    return (nbeats <= 1) ? 1 : $clog2(nbeats);
  endfunction

  // A word must split into a whole, non-zero number of non-empty lanes
  function automatic bit params_legal(input int width, input int lane);
    return (lane >= 1) && (lane <= width) && ((width % lane) == 0);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-NBEATS beat counter with synchronous clear and a terminal-count flag.
// Latency: count updates on the edge after clear/incr; terminal is combinational from count.
// Backpressure: none; the owner gates incr with its handshake.
module beat_counter #(
  parameter int NBEATS = 8,
  parameter int IW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          incr,
  output logic [IW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == IW'(NBEATS - 1));

  // Clear wins over increment; incrementing past the terminal count wraps to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_extractor.sv
// Splits a WIDTH-bit word into WIDTH/LANE beats of LANE bits, tagged with beat index and last flag.
// Latency: beat 0 is valid the cycle after acceptance; one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds the current beat; in_ready rises only when idle or on the last-beat handshake.
module serial_extractor
  import extractor_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  LANE      = 1,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int NBEATS    = (LANE > 0) ? (WIDTH / LANE) : 1,
  localparam int IW        = idx_width(NBEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANE-1:0]  out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last
);

  if (!params_legal(WIDTH, LANE)) begin : g_param_check
    $error("serial_extractor: WIDTH (%0d) must be a positive multiple of LANE (%0d)", WIDTH, LANE);
  end

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [IW-1:0]    cnt;
  logic             cnt_terminal;
  logic             beat_taken;
  logic             last_taken;
  logic             word_taken;
  logic             cnt_clear;

  // Handshakes. A new word may enter on the very cycle the last beat leaves,
  // which is what gives back-to-back words with no bubble.
  assign out_valid  = (state == SHIFT);
  assign beat_taken = out_valid && out_ready;
  assign last_taken = beat_taken && cnt_terminal;
  assign in_ready   = !flush && ((state == IDLE) || last_taken);
  assign word_taken = in_valid && in_ready;
  assign cnt_clear  = flush || word_taken || last_taken;

  // The emitting end of the shift register depends on bit order; vacated bits fill with zero
  if (MSB_FIRST) begin : g_msb_first
    assign out_data      = shreg[WIDTH-1 -: LANE];
    assign shreg_shifted = shreg << LANE;
  end else begin : g_lsb_first
    assign out_data      = shreg[LANE-1:0];
    assign shreg_shifted = shreg >> LANE;
  end

  assign out_index = cnt;
  assign out_last  = out_valid && cnt_terminal;

  // Control FSM and shift register: flush aborts, a new word reloads, a consumed beat shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (word_taken) begin
      state <= SHIFT;
      shreg <= in_data;
    end else if (beat_taken) begin
      shreg <= shreg_shifted;
      if (cnt_terminal) begin
        state <= IDLE;
      end
    end
  end

  beat_counter #(
    .NBEATS (NBEATS),
    .IW     (IW)
  ) u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .incr     (beat_taken),
    .count    (cnt),
    .terminal (cnt_terminal)
  );

endmodule

// File: tb/tb_serial_extractor.sv
// Bench for serial_extractor: four configurations driven by directed and random stimulus.
// Latency: checks are taken mid-cycle on the falling edge, inputs change 1 time unit after the rising edge.
// Backpressure: out_ready is toggled and randomised to exercise stalls.
module tb_serial_extractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // a: WIDTH=8 LANE=1 LSB first
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0] a_in_data;
  logic [0:0] a_out_data;
  logic [2:0] a_out_index;
  // b: WIDTH=8 LANE=4 MSB first
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0] b_in_data;
  logic [3:0] b_out_data;
  logic [0:0] b_out_index;
  // c: WIDTH=8 LANE=2 LSB first
  logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [7:0] c_in_data;
  logic [1:0] c_out_data;
  logic [1:0] c_out_index;
  // d: WIDTH=LANE=8
  logic d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last;
  logic [7:0] d_in_data;
  logic [7:0] d_out_data;
  logic [0:0] d_out_index;

  serial_extractor #(.WIDTH(8), .LANE(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_index(a_out_index), .out_last(a_out_last));

  serial_extractor #(.WIDTH(8), .LANE(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_index(b_out_index), .out_last(b_out_last));

  serial_extractor #(.WIDTH(8), .LANE(2), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_index(c_out_index), .out_last(c_out_last));

  serial_extractor #(.WIDTH(8), .LANE(8), .MSB_FIRST(1'b0)) dut_d (
    .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_index(d_out_index), .out_last(d_out_last));

  // Reference: beat k of an 8-bit word split into lanes of the given width and order
  function automatic logic [7:0] beat_val(input logic [7:0] w, input int k, input int lane, input bit msb);
    logic [7:0] mask;
    int sh;
    mask = 8'((1 << lane) - 1);
    sh = msb ? (8 - (k + 1) * lane) : (k * lane);
    return (w >> sh) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %0b want 0", a_out_valid); end
    n_checks++; if (a_out_index !== 3'd0) begin n_fail++; $display("FAIL reset_a_index got %0d want 0", a_out_index); end
    n_checks++; if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_a_last got %0b want 0", a_out_last); end
    n_checks++; if (a_out_data !== 1'b0) begin n_fail++; $display("FAIL reset_a_data got %0h want 0", a_out_data); end
    n_checks++; if (c_out_data !== 2'd0) begin n_fail++; $display("FAIL reset_c_data got %0h want 0", c_out_data); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %0b want 0", b_out_valid); end
    n_checks++; if (d_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_d_last got %0b want 0", d_out_last); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_a_in_ready got %0b want 1", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_b_in_ready got %0b want 1", b_in_ready); end
    n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_c_in_ready got %0b want 1", c_in_ready); end
    n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_d_in_ready got %0b want 1", d_in_ready); end
    tick();
  endtask

  task automatic test_lsb_serial();
    logic [7:0] exp_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_ready got %0b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid k=%0d got %0b want 1", k, a_out_valid); end
      n_checks++; if (a_out_data !== exp_bits[k][0:0]) begin n_fail++; $display("FAIL lsb_data k=%0d got %0h want %0h", k, a_out_data, exp_bits[k]); end
      n_checks++; if (a_out_index !== 3'(k)) begin n_fail++; $display("FAIL lsb_index got %0d want %0d", a_out_index, k); end
      n_checks++; if (a_out_last !== (k == 7)) begin n_fail++; $display("FAIL lsb_last k=%0d got %0b want %0b", k, a_out_last, k == 7); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_end_valid got %0b want 0", a_out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4] = '{4'h3, 4'hC, 4'h9, 4'h6};
    logic       exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    b_in_valid = 1'b1; b_in_data = 8'h3C; b_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got %0b want 1", b_in_ready); end
    tick();
    b_in_data = 8'h96;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid k=%0d got %0b want 1", k, b_out_valid); end
      n_checks++; if (b_out_data !== exp_d[k]) begin n_fail++; $display("FAIL b2b_data k=%0d got %0h want %0h", k, b_out_data, exp_d[k]); end
      n_checks++; if (b_out_index !== 1'(k % 2)) begin n_fail++; $display("FAIL b2b_index k=%0d got %0d want %0d", k, b_out_index, k % 2); end
      n_checks++; if (b_out_last !== exp_r[k]) begin n_fail++; $display("FAIL b2b_last k=%0d got %0b want %0b", k, b_out_last, exp_r[k]); end
      n_checks++; if (b_in_ready !== exp_r[k]) begin n_fail++; $display("FAIL b2b_in_ready k=%0d got %0b want %0b", k, b_in_ready, exp_r[k]); end
      tick();
      if (k == 1) b_in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %0b want 0", b_out_valid); end
    tick();
  endtask

  task automatic test_stall();
    int k = 0;
    int cyc = 0;
    logic ordy;
    a_in_valid = 1'b1; a_in_data = 8'hF0; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    while (k < 8 && cyc < 40) begin
      ordy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      a_out_ready = ordy;
      @(negedge clk);
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got %0b want 1", cyc, a_out_valid); end
      n_checks++; if (a_out_data !== beat_val(8'hF0, k, 1, 1'b0)) begin n_fail++; $display("FAIL stall_data cyc=%0d got %0h want %0h", cyc, a_out_data, beat_val(8'hF0, k, 1, 1'b0)); end
      n_checks++; if (a_out_index !== 3'(k)) begin n_fail++; $display("FAIL stall_index cyc=%0d got %0d want %0d", cyc, a_out_index, k); end
      n_checks++; if (a_in_ready !== (k == 7 && ordy)) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got %0b want %0b", cyc, a_in_ready, k == 7 && ordy); end
      tick();
      if (ordy) k++;
      cyc++;
    end
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL stall_timeout beats %0d want 8", k); end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got %0b want 0", a_out_valid); end
    tick();
  endtask

  task automatic test_flush();
    logic [1:0] exp_new [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    c_in_valid = 1'b1; c_in_data = 8'hE4; c_out_ready = 1'b1;
    tick();
    c_in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (c_out_data !== 2'(k)) begin n_fail++; $display("FAIL flush_pre_data k=%0d got %0d want %0d", k, c_out_data, k); end
      tick();
    end
    c_flush = 1'b1; c_in_valid = 1'b1; c_in_data = 8'h1B;
    @(negedge clk);
    n_checks++; if (c_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", c_in_ready); end
    n_checks++; if (c_out_data !== 2'd2) begin n_fail++; $display("FAIL flush_cycle_data got %0d want 2", c_out_data); end
    tick();
    c_flush = 1'b0;
    @(negedge clk);
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_drop got %0b want 0", c_out_valid); end
    n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready got %0b want 1", c_in_ready); end
    tick();
    c_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_new_valid k=%0d got %0b want 1", k, c_out_valid); end
      n_checks++; if (c_out_data !== exp_new[k]) begin n_fail++; $display("FAIL flush_new_data k=%0d got %0d want %0d", k, c_out_data, exp_new[k]); end
      n_checks++; if (c_out_index !== 2'(k)) begin n_fail++; $display("FAIL flush_new_index got %0d want %0d", c_out_index, k); end
      n_checks++; if (c_out_last !== (k == 3)) begin n_fail++; $display("FAIL flush_new_last k=%0d got %0b want %0b", k, c_out_last, k == 3); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (a_out_index !== 3'd3) begin n_fail++; $display("FAIL arst_pre_index got %0d want 3", a_out_index); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0b want 0", a_out_valid); end
    n_checks++; if (a_out_index !== 3'd0) begin n_fail++; $display("FAIL arst_index got %0d want 0", a_out_index); end
    n_checks++; if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL arst_last got %0b want 0", a_out_last); end
    #3 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_rel_ready got %0b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rel_valid got %0b want 0", a_out_valid); end
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (a_out_data !== beat_val(8'h5A, k, 1, 1'b0)) begin n_fail++; $display("FAIL arst_next_data k=%0d got %0h want %0h", k, a_out_data, beat_val(8'h5A, k, 1, 1'b0)); end
      n_checks++; if (a_out_index !== 3'(k)) begin n_fail++; $display("FAIL arst_next_index got %0d want %0d", a_out_index, k); end
      tick();
    end
  endtask

  // Random words, valid, ready and occasional flush on the 1-bit-lane instance
  task automatic test_random_lane1();
    logic [7:0] word = 8'h00;
    int pend = 0;
    int k;
    logic fl, iv, ordy, exp_rdy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      fl = ($urandom_range(0, 19) == 0);
      iv = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      a_flush = fl; a_in_valid = iv; a_in_data = 8'($urandom); a_out_ready = ordy;
      @(negedge clk);
      exp_rdy = !fl && (pend == 0 || (pend == 1 && ordy));
      n_checks++; if (a_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd1_in_ready cyc=%0d got %0b want %0b", cyc, a_in_ready, exp_rdy); end
      n_checks++; if (a_out_valid !== (pend > 0)) begin n_fail++; $display("FAIL rnd1_valid cyc=%0d got %0b want %0b", cyc, a_out_valid, pend > 0); end
      if (pend > 0) begin
        k = 8 - pend;
        n_checks++; if (a_out_data !== beat_val(word, k, 1, 1'b0)) begin n_fail++; $display("FAIL rnd1_data cyc=%0d got %0h want %0h", cyc, a_out_data, beat_val(word, k, 1, 1'b0)); end
        n_checks++; if (a_out_index !== 3'(k)) begin n_fail++; $display("FAIL rnd1_index cyc=%0d got %0d want %0d", cyc, a_out_index, k); end
        n_checks++; if (a_out_last !== (pend == 1)) begin n_fail++; $display("FAIL rnd1_last cyc=%0d got %0b want %0b", cyc, a_out_last, pend == 1); end
      end
      if (fl) pend = 0;
      else if (iv && exp_rdy) begin word = a_in_data; pend = 8; end
      else if (pend > 0 && ordy) pend--;
      tick();
    end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  // Single-beat configuration: output stream must equal input stream, every beat last
  task automatic test_random_pipe();
    logic [7:0] accepted [$];
    int delivered = 0;
    int taken = 0;
    logic iv, ordy, exp_rdy;
    for (int cyc = 0; cyc < 200; cyc++) begin
      iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      d_in_valid = iv; d_in_data = 8'($urandom); d_out_ready = ordy;
      @(negedge clk);
      exp_rdy = (accepted.size() == 0) || ordy;
      n_checks++; if (d_in_ready !== exp_rdy) begin n_fail++; $display("FAIL pipe_in_ready cyc=%0d got %0b want %0b", cyc, d_in_ready, exp_rdy); end
      n_checks++; if (d_out_valid !== (accepted.size() != 0)) begin n_fail++; $display("FAIL pipe_valid cyc=%0d got %0b want %0b", cyc, d_out_valid, accepted.size() != 0); end
      if (accepted.size() != 0) begin
        n_checks++; if (d_out_data !== accepted[0]) begin n_fail++; $display("FAIL pipe_data cyc=%0d got %0h want %0h", cyc, d_out_data, accepted[0]); end
        n_checks++; if (d_out_last !== 1'b1) begin n_fail++; $display("FAIL pipe_last cyc=%0d got %0b want 1", cyc, d_out_last); end
        n_checks++; if (d_out_index !== 1'b0) begin n_fail++; $display("FAIL pipe_index cyc=%0d got %0d want 0", cyc, d_out_index); end
        if (ordy) begin void'(accepted.pop_front()); delivered++; end
      end
      if (iv && exp_rdy) begin accepted.push_back(d_in_data); taken++; end
      tick();
    end
    n_checks++; if (taken - delivered != accepted.size() || accepted.size() > 1) begin n_fail++; $display("FAIL pipe_occupancy taken %0d delivered %0d held %0d", taken, delivered, accepted.size()); end
    d_in_valid = 1'b0; d_out_ready = 1'b0;
  endtask

  initial begin
    a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    d_flush = 0; d_in_valid = 0; d_in_data = 0; d_out_ready = 0;
    test_reset();
    test_lsb_serial();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random_lane1();
    test_random_pipe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
